// File: rtl/bridge_pkg.sv
// bridge_pkg: state encoding, AXI response codes and byte-address helper shared by the burst bridge
package bridge_pkg;
   typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   function automatic logic [63:0] addr_calc(input logic [63:0] base, input logic [63:0] idx, input logic [63:0] bytes);
      return base + idx * bytes;
   endfunction
endpackage

// File: rtl/axi_wskid.sv
// axi_wskid: one-entry pipeline buffer with valid/ready on both sides
module axi_wskid #(
   parameter int DW = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data
);
   logic full;
   logic [DW-1:0] data;
   assign s_ready = !full || m_ready;
   assign m_valid = full;
   assign m_data = data;
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         data <= '0;
      end else if (s_valid && s_ready) begin
         full <= 1'b1;
         data <= s_data;
      end else if (m_ready) begin
         full <= 1'b0;
      end
   end
endmodule

// File: rtl/axi_burst_bridge.sv
// axi_burst_bridge: turns client read/write requests into AXI4 bursts with RESP/RLAST error reporting
module axi_burst_bridge
   import bridge_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32,
   parameter int IDX_W = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0001_0000,
   parameter int MAX_LEN = 8,
   parameter int LEN_W = $clog2(MAX_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              C_in_valid,
   output logic              C_in_ready,
   input  logic              C_r_wb,
   input  logic [IDX_W-1:0]  C_addr,
   input  logic [LEN_W-1:0]  C_len,
   input  logic              C_wd_valid,
   output logic              C_wd_ready,
   input  logic [DATA_W-1:0] C_data_w,
   output logic              C_out_valid,
   output logic [DATA_W-1:0] C_data_r,
   output logic              C_last,
   output logic              C_err,
   output logic              AR_VALID,
   input  logic              AR_READY,
   output logic [ADDR_W-1:0] AR_ADDR,
   output logic [7:0]        AR_LEN,
   input  logic              R_VALID,
   output logic              R_READY,
   input  logic [DATA_W-1:0] R_DATA,
   input  logic [1:0]        R_RESP,
   input  logic              R_LAST,
   output logic              AW_VALID,
   input  logic              AW_READY,
   output logic [ADDR_W-1:0] AW_ADDR,
   output logic [7:0]        AW_LEN,
   output logic              W_VALID,
   input  logic              W_READY,
   output logic [DATA_W-1:0] W_DATA,
   output logic              W_LAST,
   input  logic              B_VALID,
   output logic              B_READY,
   input  logic [1:0]        B_RESP
);
   localparam int BYTES = DATA_W / 8;
   state_t st, nx;
   logic r_wb, err, acc, rh, wh, bh, at_last, w_open, err_n, sk_ready, sk_full;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W:0] cnt, wacc;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] sk_data;
   assign acc = C_in_valid && st == IDLE;
   assign rh = R_VALID && st == R;
   assign wh = sk_full && W_READY;
   assign bh = B_VALID && st == B;
   assign at_last = cnt == {1'b0, len_q};
   assign w_open = st == W && wacc <= {1'b0, len_q};
   // a beat whose RLAST disagrees with the expected position taints the whole burst
   assign err_n = err || |(R_RESP & RESP_SLVERR) || (R_LAST != at_last);
   axi_wskid #(.DW(DATA_W)) u_wskid (
      .clk(clk), .rst(rst),
      .s_valid(C_wd_valid && w_open), .s_ready(sk_ready), .s_data(C_data_w),
      .m_valid(sk_full), .m_ready(W_READY), .m_data(sk_data)
   );
   always_ff @(posedge clk) st <= rst ? IDLE : nx;
   always_comb begin
      C_in_ready = st == IDLE;
      AR_VALID = st == AR;
      AW_VALID = st == AW;
      R_READY = st == R;
      B_READY = st == B;
      AR_ADDR = (st != IDLE && r_wb) ? addr_q : '0;
      AW_ADDR = (st != IDLE && !r_wb) ? addr_q : '0;
      AR_LEN = (st != IDLE && r_wb) ? 8'(len_q) : '0;
      AW_LEN = (st != IDLE && !r_wb) ? 8'(len_q) : '0;
      W_VALID = sk_full;
      W_DATA = sk_full ? sk_data : '0;
      W_LAST = sk_full && at_last;
      C_wd_ready = w_open && sk_ready;
      nx = st;
      case (st)
         IDLE: nx = C_in_valid ? (C_r_wb ? AR : AW) : IDLE;
         AR: nx = AR_READY ? R : AR;
         R: nx = (R_VALID && at_last) ? DONE : R;
         AW: nx = AW_READY ? W : AW;
         W: nx = (wh && at_last) ? B : W;
         B: nx = B_VALID ? DONE : B;
         default: nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wb <= 1'b0;
         len_q <= '0;
         addr_q <= '0;
         cnt <= '0;
         wacc <= '0;
         err <= 1'b0;
         C_out_valid <= 1'b0;
         C_data_r <= '0;
         C_last <= 1'b0;
         C_err <= 1'b0;
      end else begin
         C_out_valid <= rh || bh;
         C_data_r <= rh ? R_DATA : '0;
         C_last <= (rh && at_last) || bh;
         C_err <= (rh && at_last) ? err_n : (bh && B_RESP[1]);
         if (acc) begin
            r_wb <= C_r_wb;
            len_q <= C_len;
            addr_q <= ADDR_W'(addr_calc(64'(BASE_ADDR), 64'(C_addr), 64'(BYTES)));
            cnt <= '0;
            wacc <= '0;
            err <= 1'b0;
         end
         if (rh || wh) cnt <= cnt + 1'b1;
         if (rh) err <= err_n;
         if (C_wd_valid && C_wd_ready) wacc <= wacc + 1'b1;
      end
   end
endmodule

// File: tb/tb_axi_burst_bridge.sv
// tb_axi_burst_bridge: directed scenarios for the burst bridge with an inline AXI slave and client
module tb_axi_burst_bridge;
   localparam int DW = 64, AW = 32, OW = 2 * AW + 16 + 2 * DW + 10;
   logic clk = 1'b0, rst = 1'b1;
   logic c_in_valid = 0, c_r_wb = 0, c_wd_valid = 0, ar_ready = 0, r_valid = 0, r_last = 0;
   logic aw_ready = 0, w_ready = 0, b_valid = 0;
   logic [7:0] c_addr = 0;
   logic [2:0] c_len = 0;
   logic [DW-1:0] c_data_w = 0, r_data = 0;
   logic [1:0] r_resp = 0, b_resp = 0;
   logic C_in_ready, C_wd_ready, C_out_valid, C_last, C_err, AR_VALID, R_READY, AW_VALID, W_VALID, W_LAST, B_READY;
   logic [DW-1:0] C_data_r, W_DATA;
   logic [AW-1:0] AR_ADDR, AW_ADDR;
   logic [7:0] AR_LEN, AW_LEN;
   logic C_in_ready2, C_wd_ready2, C_out_valid2, C_last2, C_err2, AR_VALID2, R_READY2, AW_VALID2, W_VALID2, W_LAST2, B_READY2;
   logic [DW-1:0] C_data_r2, W_DATA2;
   logic [AW-1:0] AR_ADDR2, AW_ADDR2;
   logic [7:0] AR_LEN2, AW_LEN2;
   logic [OW-1:0] outs, outs2;
   int vecs = 0, errs = 0;

   always #5 clk = ~clk;

   assign outs = {AR_VALID, AR_ADDR, AR_LEN, R_READY, AW_VALID, AW_ADDR, AW_LEN, W_VALID, W_DATA, W_LAST,
                  B_READY, C_wd_ready, C_out_valid, C_data_r, C_last, C_err};
   assign outs2 = {AR_VALID2, AR_ADDR2, AR_LEN2, R_READY2, AW_VALID2, AW_ADDR2, AW_LEN2, W_VALID2, W_DATA2, W_LAST2,
                   B_READY2, C_wd_ready2, C_out_valid2, C_data_r2, C_last2, C_err2};

   axi_burst_bridge dut (
      .clk(clk), .rst(rst), .C_in_valid(c_in_valid), .C_in_ready(C_in_ready), .C_r_wb(c_r_wb),
      .C_addr(c_addr), .C_len(c_len), .C_wd_valid(c_wd_valid), .C_wd_ready(C_wd_ready), .C_data_w(c_data_w),
      .C_out_valid(C_out_valid), .C_data_r(C_data_r), .C_last(C_last), .C_err(C_err),
      .AR_VALID(AR_VALID), .AR_READY(ar_ready), .AR_ADDR(AR_ADDR), .AR_LEN(AR_LEN),
      .R_VALID(r_valid), .R_READY(R_READY), .R_DATA(r_data), .R_RESP(r_resp), .R_LAST(r_last),
      .AW_VALID(AW_VALID), .AW_READY(aw_ready), .AW_ADDR(AW_ADDR), .AW_LEN(AW_LEN),
      .W_VALID(W_VALID), .W_READY(w_ready), .W_DATA(W_DATA), .W_LAST(W_LAST),
      .B_VALID(b_valid), .B_READY(B_READY), .B_RESP(b_resp)
   );

   axi_burst_bridge #(.BASE_ADDR(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst(rst), .C_in_valid(c_in_valid), .C_in_ready(C_in_ready2), .C_r_wb(c_r_wb),
      .C_addr(c_addr), .C_len(c_len), .C_wd_valid(c_wd_valid), .C_wd_ready(C_wd_ready2), .C_data_w(c_data_w),
      .C_out_valid(C_out_valid2), .C_data_r(C_data_r2), .C_last(C_last2), .C_err(C_err2),
      .AR_VALID(AR_VALID2), .AR_READY(ar_ready), .AR_ADDR(AR_ADDR2), .AR_LEN(AR_LEN2),
      .R_VALID(r_valid), .R_READY(R_READY2), .R_DATA(r_data), .R_RESP(r_resp), .R_LAST(r_last),
      .AW_VALID(AW_VALID2), .AW_READY(aw_ready), .AW_ADDR(AW_ADDR2), .AW_LEN(AW_LEN2),
      .W_VALID(W_VALID2), .W_READY(w_ready), .W_DATA(W_DATA2), .W_LAST(W_LAST2),
      .B_VALID(b_valid), .B_READY(B_READY2), .B_RESP(b_resp)
   );

   function automatic logic [DW-1:0] rdat(input int idx, input int beat);
      return 64'hA000_0000_0000_0000 | (64'(idx) << 8) | 64'(beat);
   endfunction

   function automatic logic [DW-1:0] wdat(input int idx, input int beat);
      return 64'h5A5A_0000_0000_0000 ^ (64'(idx) << 16) ^ 64'(beat);
   endfunction

   task automatic run_read(input int idx, input int len, input bit gap, input int err_beat, input int last_beat,
                           input logic [AW-1:0] ea, input logic [AW-1:0] ea2, input bit exp_err, input int abort_at);
      int b = 0, g = 0, cyc = 0;
      bit hs = 0, on, aborted = 0;
      @(negedge clk);
      c_in_valid = 1; c_r_wb = 1; c_addr = 8'(idx); c_len = 3'(len); ar_ready = 1;
      repeat (100) begin
         @(negedge clk);
         if (hs) b++;
         if (cyc == 0) begin
            c_in_valid = 0;
            vecs++;
            if (AR_VALID !== 1'b1 || AR_ADDR !== ea || AR_LEN !== 8'(len))
               begin errs++; $display("FAIL rd_ar: valid=%b addr=%h len=%0d, want 1 %h %0d", AR_VALID, AR_ADDR, AR_LEN, ea, len); end
            vecs++;
            if (AR_ADDR2 !== ea2) begin errs++; $display("FAIL rd_ar_wrap: addr=%h, want %h", AR_ADDR2, ea2); end
         end
         vecs++;
         if (C_out_valid === 1'b1) begin
            if (C_data_r !== rdat(idx, g) || C_last !== (g == len) || C_err !== ((g == len) ? exp_err : 1'b0))
               begin errs++; $display("FAIL rd_beat%0d: data=%h last=%b err=%b, want %h %b %b", g, C_data_r, C_last, C_err,
                                      rdat(idx, g), g == len, (g == len) ? exp_err : 1'b0); end
            g++;
         end else if (C_data_r !== '0 || C_last !== 1'b0) begin
            errs++; $display("FAIL rd_idle_out: data=%h last=%b, want 0 0", C_data_r, C_last);
         end
         if (abort_at >= 0 && g == abort_at) begin aborted = 1; break; end
         if (g > len) break;
         on = (b <= len) && (!gap || cyc % 2 == 1);
         r_valid = on; r_data = on ? rdat(idx, b) : '0;
         r_last = on && b == last_beat;
         r_resp = (on && b == err_beat) ? 2'b10 : 2'b00;
         hs = on && R_READY;
         cyc++;
      end
      if (!aborted) begin
         r_valid = 0; r_last = 0; r_resp = 0;
         vecs++;
         if (g != len + 1) begin errs++; $display("FAIL rd_count: got %0d beats, want %0d", g, len + 1); end
         @(negedge clk);
         vecs++;
         if (C_out_valid !== 1'b0 || C_in_ready !== 1'b1)
            begin errs++; $display("FAIL rd_done: out_valid=%b in_ready=%b, want 0 1", C_out_valid, C_in_ready); end
      end
   endtask

   task automatic run_write(input int idx, input int len, input int stall_beat, input int stall_n,
                            input logic [1:0] bresp, input logic [AW-1:0] ea, input bit exp_err);
      int k = 0, j = 0, cyc = 0, stall = stall_n, pulses = 0;
      bit chs = 0, whs = 0;
      @(negedge clk);
      c_in_valid = 1; c_r_wb = 0; c_addr = 8'(idx); c_len = 3'(len);
      c_wd_valid = 1; c_data_w = wdat(idx, 0); aw_ready = 0; w_ready = 0; b_resp = bresp;
      repeat (100) begin
         @(negedge clk);
         if (chs) k++;
         if (whs) j++;
         if (C_out_valid === 1'b1) begin
            vecs++;
            if (C_last !== 1'b1 || C_err !== exp_err || C_data_r !== '0)
               begin errs++; $display("FAIL wr_resp: last=%b err=%b data=%h, want 1 %b 0", C_last, C_err, C_data_r, exp_err); end
            pulses++;
            break;
         end
         if (cyc == 0) c_in_valid = 0;
         aw_ready = cyc >= 1;
         w_ready = !(W_VALID && j == stall_beat && stall > 0);
         c_data_w = wdat(idx, k);
         b_valid = B_READY;
         #1;
         if (cyc == 0) begin
            vecs++;
            if (AW_VALID !== 1'b1 || AW_ADDR !== ea || AW_LEN !== 8'(len) || C_wd_ready !== 1'b0)
               begin errs++; $display("FAIL wr_aw: valid=%b addr=%h len=%0d wd_ready=%b, want 1 %h %0d 0",
                                      AW_VALID, AW_ADDR, AW_LEN, C_wd_ready, ea, len); end
         end
         if (W_VALID && w_ready) begin
            vecs++;
            if (W_DATA !== wdat(idx, j) || W_LAST !== (j == len))
               begin errs++; $display("FAIL wr_beat%0d: data=%h last=%b, want %h %b", j, W_DATA, W_LAST, wdat(idx, j), j == len); end
         end
         if (W_VALID && !w_ready) begin
            stall--;
            vecs++;
            if (C_wd_ready !== 1'b0) begin errs++; $display("FAIL wr_stall_ready: wd_ready=%b, want 0", C_wd_ready); end
         end
         chs = c_wd_valid && C_wd_ready;
         whs = W_VALID && w_ready;
         cyc++;
      end
      c_wd_valid = 0; b_valid = 0; aw_ready = 0; w_ready = 0;
      vecs++;
      if (pulses != 1 || j != len + 1 || k != len + 1)
         begin errs++; $display("FAIL wr_count: pulses=%0d wbeats=%0d accepted=%0d, want 1 %0d %0d", pulses, j, k, len + 1, len + 1); end
      @(negedge clk);
      vecs++;
      if (C_out_valid !== 1'b0 || C_in_ready !== 1'b1)
         begin errs++; $display("FAIL wr_done: out_valid=%b in_ready=%b, want 0 1", C_out_valid, C_in_ready); end
   endtask

   task automatic test_reset;
      rst = 1;
      repeat (3) @(negedge clk);
      vecs++;
      if (outs !== '0 || C_in_ready !== 1'b1) begin errs++; $display("FAIL reset: outs=%h in_ready=%b, want 0 1", outs, C_in_ready); end
      vecs++;
      if (outs2 !== '0) begin errs++; $display("FAIL reset_wrap: outs=%h, want 0", outs2); end
      rst = 0;
   endtask

   task automatic test_single_read;
      run_read(3, 0, 0, -1, 0, 32'h0001_0018, 32'h0000_0010, 0, -1);
   endtask

   task automatic test_read_burst;
      run_read(0, 7, 1, -1, 7, 32'h0001_0000, 32'hFFFF_FFF8, 0, -1);
   endtask

   task automatic test_write_burst;
      run_write(255, 3, 1, 2, 2'b00, 32'h0001_07F8, 0);
   endtask

   task automatic test_errors;
      run_write(4, 0, -1, 0, 2'b10, 32'h0001_0020, 1);
      run_read(5, 3, 0, 2, 3, 32'h0001_0028, 32'h0000_0020, 1, -1);
      run_read(6, 3, 0, -1, 1, 32'h0001_0030, 32'h0000_0028, 1, -1);
   endtask

   task automatic test_reset_midop;
      run_read(0, 7, 0, -1, 7, 32'h0001_0000, 32'hFFFF_FFF8, 0, 2);
      rst = 1; r_valid = 1;
      @(negedge clk);
      vecs++;
      if (outs !== '0 || C_in_ready !== 1'b1) begin errs++; $display("FAIL midop_reset: outs=%h in_ready=%b, want 0 1", outs, C_in_ready); end
      rst = 0; r_valid = 0; r_last = 0;
      run_read(1, 0, 0, -1, 0, 32'h0001_0008, 32'h0000_0000, 0, -1);
   endtask

   task automatic test_wrap;
      run_read(2, 0, 0, -1, 0, 32'h0001_0010, 32'h0000_0008, 0, -1);
   endtask

   initial begin
      test_reset;
      test_single_read;
      test_read_burst;
      test_write_burst;
      test_errors;
      test_reset_midop;
      test_wrap;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
